seven_segment_controller: RTL and testbench

//  Time-multiplexes a 32-bit value onto an 8-digit common-anode seven-segment display.

---
 rtl/seven_segment_controller_pkg.sv | 11 +
 rtl/seven_segment_controller_if.sv | 13 +
 rtl/seven_segment_controller_bto7s.sv | 30 +++
 rtl/seven_segment_controller.sv | 74 +++++++
 tb/tb_seven_segment_controller.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_controller_pkg.sv
// Shared definitions for the seven-segment display controller.
//   NUM_DIGITS  : number of multiplexed digits on the display
//   SEG_OFF     : cathode pattern with every segment dark (active-low)
//   AN_OFF      : anode pattern with every digit dark (active-low)
//   digit_idx_t : index of the digit currently being scanned
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  typedef logic [2:0] digit_idx_t;
endpackage

// File: rtl/seven_segment_controller_if.sv
// Value-source side of the display controller.
//   val_in       : 32-bit value, nibble k shown on digit k
//   val_valid_in : capture strobe for val_in
//   digit_en_in  : per-digit enable, 0 keeps that digit dark
// master = status/debug logic producing the value, slave = the controller.
interface seven_segment_controller_if;
  logic [31:0] val_in;
  logic        val_valid_in;
  logic [7:0]  digit_en_in;

  modport master (output val_in, output val_valid_in, output digit_en_in);
  modport slave  (input  val_in, input  val_valid_in, input  digit_en_in);
endinterface

// File: rtl/seven_segment_controller_bto7s.sv
// Hex nibble to seven-segment decoder (combinational).
//   nib_in  : 4-bit hex digit
//   seg_out : segments {g,f,e,d,c,b,a}, active-high (1 = segment lit)
module bto7s (
  input  logic [3:0] nib_in,
  output logic [6:0] seg_out
);
  always_comb begin
    seg_out = 7'h00;
    case (nib_in)
      4'h0: seg_out = 7'h3F;
      4'h1: seg_out = 7'h06;
      4'h2: seg_out = 7'h5B;
      4'h3: seg_out = 7'h4F;
      4'h4: seg_out = 7'h66;
      4'h5: seg_out = 7'h6D;
      4'h6: seg_out = 7'h7D;
      4'h7: seg_out = 7'h07;
      4'h8: seg_out = 7'h7F;
      4'h9: seg_out = 7'h6F;
      4'hA: seg_out = 7'h77;
      4'hB: seg_out = 7'h7C;
      4'hC: seg_out = 7'h39;
      4'hD: seg_out = 7'h5E;
      4'hE: seg_out = 7'h79;
      4'hF: seg_out = 7'h71;
      default: seg_out = 7'h00;
    endcase
  end
endmodule

// File: rtl/seven_segment_controller.sv
// Time-multiplexes a 32-bit value onto an 8-digit common-anode display.
//   clk_in  : system clock
//   rst_in  : synchronous reset, active-high
//   src     : value source (val_in, val_valid_in, digit_en_in)
//   cat_out : cathodes {g..a}, active-low
//   an_out  : anodes, active-low, at most one low at a time
// Each digit owns REFRESH_CYCLES clocks; the last BLANK_CYCLES of a slot
// keep every anode off so the previous glyph cannot ghost onto the next digit.
module seven_segment_controller
  import seg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100_000,
  parameter int BLANK_CYCLES   = 1_000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  seven_segment_controller_if.slave   src,
  output logic [6:0]                  cat_out,
  output logic [7:0]                  an_out
);
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  // One extra bit: the lit window end may equal REFRESH_CYCLES itself.
  localparam logic [CNT_W:0] LIT_END = (CNT_W + 1)'(REFRESH_CYCLES - BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [3:0]       nib_q, nib_d;
  logic [6:0]       cat_q, cat_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg;
  logic             wrap;
  logic             lit;

  bto7s u_bto7s (
    .nib_in  (nib_q),
    .seg_out (seg)
  );

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d    = wrap ? idx_q + 3'd1 : idx_q;
    shadow_d = src.val_valid_in ? src.val_in : shadow_q;
    // Reads the registered shadow, so a same-cycle capture only shows from
    // the following slot and never changes a glyph mid-slot.
    nib_d    = wrap ? shadow_q[{idx_d, 2'b00} +: 4] : nib_q;
    lit      = ({1'b0, cnt_q} < LIT_END) && src.digit_en_in[idx_q];
    an_d     = lit ? ~(8'd1 << idx_q) : AN_OFF;
    cat_d    = lit ? ~seg : SEG_OFF;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      nib_q    <= '0;
      an_q     <= AN_OFF;
      cat_q    <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      nib_q    <= nib_d;
      an_q     <= an_d;
      cat_q    <= cat_d;
    end
  end

  assign an_out  = an_q;
  assign cat_out = cat_q;
endmodule

// File: tb/tb_seven_segment_controller.sv
// Self-checking bench: a gap build (BLANK=1) and a no-gap build (BLANK=0)
// run side by side on shared stimulus against a slot-arithmetic model.
module tb_seven_segment_controller;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] val = '0;
  logic        valid = 1'b0;
  logic [7:0]  en = 8'hFF;

  logic [6:0] cat0, cat1;
  logic [7:0] an0, an1;

  seven_segment_controller_if bus0 ();
  seven_segment_controller_if bus1 ();
  assign bus0.val_in = val;
  assign bus0.val_valid_in = valid;
  assign bus0.digit_en_in = en;
  assign bus1.val_in = val;
  assign bus1.val_valid_in = valid;
  assign bus1.digit_en_in = en;

  seven_segment_controller #(.REFRESH_CYCLES(R), .BLANK_CYCLES(1)) dut (
    .clk_in(clk), .rst_in(rst), .src(bus0), .cat_out(cat0), .an_out(an0));
  seven_segment_controller #(.REFRESH_CYCLES(R), .BLANK_CYCLES(0)) dut_nogap (
    .clk_in(clk), .rst_in(rst), .src(bus1), .cat_out(cat1), .an_out(an1));

  always #5 clk = ~clk;

  // Segment patterns {g..a}, active-high, for hex digits 0..F.
  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state per build: clocks since reset release, captured value,
  // and the nibble chosen for the slot in progress.
  int          m_n  [2];
  logic [31:0] m_sh [2];
  logic [3:0]  m_nib[2];
  logic [7:0]  e_an [2];
  logic [6:0]  e_cat[2];
  int          m_blank[2] = '{1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_edge(input int i);
    int c, d;
    logic lit;
    if (rst) begin
      e_an[i] = 8'hFF; e_cat[i] = 7'h7F;
      m_n[i] = 0; m_sh[i] = '0; m_nib[i] = '0;
    end else begin
      c = m_n[i] % R;
      d = (m_n[i] / R) % 8;
      lit = (c < R - m_blank[i]) && en[d];
      e_an[i]  = lit ? ~(8'd1 << d) : 8'hFF;
      e_cat[i] = lit ? ~gly[m_nib[i]] : 7'h7F;
      if (c == R - 1) m_nib[i] = 4'((m_sh[i] >> (4 * ((d + 1) % 8))) & 32'hF);
      if (valid) m_sh[i] = val;
      m_n[i]++;
    end
  endtask

  function automatic int zeros(input logic [7:0] a);
    int z = 0;
    for (int k = 0; k < 8; k++) if (!a[k]) z++;
    return z;
  endfunction

  // One clock: model both builds, then compare after the edge settles.
  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("an_gap", an0, e_an[0]);
    chk("cat_gap", cat0, e_cat[0]);
    chk("an_nogap", an1, e_an[1]);
    chk("cat_nogap", cat1, e_cat[1]);
    if (zeros(an0) > 1) chk("an_gap_onehot", zeros(an0), 1);
    if (zeros(an1) > 1) chk("an_nogap_onehot", zeros(an1), 1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    valid = 1'b0;
    for (int k = 0; k < cycles; k++) cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] v;
    logic [7:0]  an;
    logic [6:0]  cat;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [6:0] seen_cat;
    logic seen;

    vecs[0] = '{32'h1234_5678, 8'hFE, 7'h00};
    vecs[1] = '{32'h1234_5678, 8'h7F, 7'h79};
    vecs[2] = '{32'hFFFF_FFFF, 8'hF7, 7'h0E};
    vecs[3] = '{32'h0000_0000, 8'hDF, 7'h40};
    vecs[4] = '{32'hDEAD_BEEF, 8'hEF, 7'h21};
    vecs[5] = '{32'h89AB_CDEF, 8'hBF, 7'h10};

    // Reset held: outputs dark every cycle, then digit 0 shows "0".
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_an", an0, 8'hFF);
      chk("rst_cat", cat0, 7'h7F);
    end
    rst = 1'b0;
    cyc();
    chk("first_an", an0, 8'hFE);
    chk("first_cat", cat0, 7'h40);

    // Table: load a value, run two scans, keep the last glyph seen on the digit.
    for (int t = 0; t < 6; t++) begin
      do_reset(2);
      en = 8'hFF;
      val = vecs[t].v;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      seen = 1'b0;
      seen_cat = '0;
      for (int k = 0; k < 16 * R; k++) begin
        cyc();
        if (an0 == vecs[t].an) begin seen = 1'b1; seen_cat = cat0; end
        if (k > 0) chk("nogap_one_low", zeros(an1), 1);
      end
      chk("tbl_seen", seen, 1'b1);
      chk("tbl_cat", seen_cat, vecs[t].cat);
    end

    // Enable mask: upper digits stay dark, lower digits still scan.
    do_reset(2);
    en = 8'h0F;
    for (int k = 0; k < 64; k++) begin
      cyc();
      chk("mask_hi", an0[7:4], 4'hF);
    end
    en = 8'hFF;

    // Mid-slot update during digit 2 (cnt=1).
    do_reset(2);
    val = 32'h1234_5678;
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    for (int k = 1; k <= 8; k++) cyc();
    val = 32'hFFFF_FFFF;
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    cyc();
    chk("mid_an2", an0, 8'hFB);
    chk("mid_cat2", cat0, 7'h02);
    cyc();
    cyc();
    chk("mid_an3", an0, 8'hF7);
    chk("mid_cat3", cat0, 7'h0E);

    // Reset during digit 5 of the second scan.
    for (int k = 0; k < 42; k++) cyc();
    chk("pre_rst_an", an0, 8'hDF);
    rst = 1'b1;
    cyc();
    chk("midrst_an", an0, 8'hFF);
    chk("midrst_cat", cat0, 7'h7F);
    rst = 1'b0;
    cyc();
    chk("restart_an", an0, 8'hFE);
    chk("restart_cat", cat0, 7'h40);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      valid = ($urandom_range(7) == 0);
      val = $urandom;
      if ($urandom_range(40) == 0) en = 8'($urandom);
      rst = ($urandom_range(250) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
